// File: rtl/vga_rtc_pkg.sv
// Shared types and 640x480 timing defaults for the RTC/VGA display front end.
// Combinational only: no latency, no backpressure.
package vga_rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_CAPT,
    ST_COMMIT
  } fetch_st_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider, h/v counters and registered hsync/vsync/video_on.
// Syncs and video_on lag the counters by 1 clk; free running, no backpressure.
module vga_timing_gen
  import vga_rtc_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       v_wrap
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             h_last;
  logic             v_last;
  logic             h_in_sync;
  logic             v_in_sync;

  assign pixel_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_last     = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last     = (v_cnt == 10'(V_TOTAL - 1));
  assign v_wrap     = pixel_tick & h_last & v_last;
  assign pixel_x    = h_cnt;
  assign pixel_y    = v_cnt;

  assign h_in_sync = (h_cnt >= 10'(H_ACTIVE + H_FP)) && (h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC));
  assign v_in_sync = (v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC));

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pixel_tick ? '0 : div_cnt + DIV_W'(1);
      if (pixel_tick) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // All three outputs share one register stage so they stay mutually aligned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      video_on <= 1'b0;
    end else begin
      hsync    <= h_in_sync ? SYNC_POL : ~SYNC_POL;
      vsync    <= v_in_sync ? SYNC_POL : ~SYNC_POL;
      video_on <= (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    end
  end

endmodule

// File: rtl/vga_rtc_frontend.sv
// RTC/VGA front end: timing, vblank RTC field fetch with atomic commit, alarm ring.
// Commit costs NUM_FIELDS*(SETTLE_CYC+2)+1 clks; no backpressure; ALARM_BLINK_EN adds blink.
module vga_rtc_frontend
  import vga_rtc_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter bit SYNC_POL     = 1'b0,
  parameter int NUM_FIELDS   = 9,
  parameter int SEL_W        = 4,
  parameter int SETTLE_CYC   = 4,
  parameter int RING_FRAMES  = 600,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              dato,
  input  logic                    rtcin,
  input  logic                    alarm_ack,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    video_on,
  output logic                    pixel_tick,
  output logic [9:0]              pixel_x,
  output logic [9:0]              pixel_y,
  output logic [SEL_W-1:0]        selector_dato,
  output logic [8*NUM_FIELDS-1:0] field_data,
  output logic                    frame_valid,
  output logic                    fetch_err,
  output logic                    alarma
);

  localparam int SET_W   = $clog2(SETTLE_CYC + 1);
  localparam int FRM_MAX = (RING_FRAMES > BLINK_FRAMES) ? RING_FRAMES : BLINK_FRAMES;
  localparam int FRM_W   = $clog2(FRM_MAX + 1) + 1;

  logic v_wrap;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .pixel_tick(pixel_tick),
    .hsync     (hsync),
    .vsync     (vsync),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .v_wrap    (v_wrap)
  );

  fetch_st_t               state;
  fetch_st_t               state_nxt;
  logic [SEL_W-1:0]        idx;
  logic [SET_W-1:0]        settle_cnt;
  logic [8*NUM_FIELDS-1:0] shadow;
  logic                    fetch_start;
  logic                    idx_last;

  assign fetch_start = pixel_tick && (pixel_y == 10'(V_ACTIVE)) && (pixel_x == 10'd0);
  assign idx_last    = (idx == SEL_W'(NUM_FIELDS - 1));
  assign selector_dato = (state == ST_ADDR || state == ST_WAIT || state == ST_CAPT) ? idx : '1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (fetch_start) state_nxt = ST_ADDR;
      ST_ADDR:   state_nxt = ST_WAIT;
      ST_WAIT:   if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_nxt = ST_CAPT;
      ST_CAPT:   state_nxt = idx_last ? ST_COMMIT : ST_ADDR;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    // A frame boundary mid-fetch would mix two frames' time; drop the bank.
    if (v_wrap && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      settle_cnt  <= '0;
      shadow      <= '0;
      field_data  <= '0;
      frame_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_valid <= (state == ST_COMMIT) && !v_wrap;
      fetch_err   <= (state != ST_IDLE) && v_wrap;
      settle_cnt  <= (state == ST_WAIT) ? settle_cnt + SET_W'(1) : '0;
      if (state == ST_IDLE) idx <= '0;
      if (state == ST_CAPT) begin
        shadow[8*idx +: 8] <= dato;
        if (!idx_last) idx <= idx + SEL_W'(1);
      end
      if (state == ST_COMMIT && !v_wrap) field_data <= shadow;
    end
  end

  logic             rtc_s0;
  logic             rtc_s1;
  logic             rtc_s1_d;
  logic             ring;
  logic             ring_set;
  logic [FRM_W-1:0] ring_cnt;
  logic [FRM_W-1:0] ring_cnt_nxt;

  assign ring_set     = rtc_s1 & ~rtc_s1_d;
  assign ring_cnt_nxt = ring_cnt + FRM_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rtc_s0   <= 1'b0;
      rtc_s1   <= 1'b0;
      rtc_s1_d <= 1'b0;
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else begin
      rtc_s0   <= rtcin;
      rtc_s1   <= rtc_s0;
      rtc_s1_d <= rtc_s1;
      if (ring_set) begin
        ring     <= 1'b1;
        ring_cnt <= '0;
      end else if (alarm_ack) begin
        ring <= 1'b0;
      end else if (ring && v_wrap) begin
        if (RING_FRAMES != 0 && ring_cnt_nxt == FRM_W'(RING_FRAMES)) begin
          ring     <= 1'b0;
          ring_cnt <= '0;
        end else begin
          ring_cnt <= ring_cnt_nxt;
        end
      end
    end
  end

`ifdef ALARM_BLINK_EN
  logic             blink;
  logic [FRM_W-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (ring_set) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (ring && v_wrap) begin
      if (blink_cnt + FRM_W'(1) == FRM_W'(BLINK_FRAMES)) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + FRM_W'(1);
      end
    end
  end

  assign alarma = ring & blink;
`else
  assign alarma = ring;
`endif

endmodule

// File: tb/tb_vga_rtc_frontend.sv
// Directed bench for vga_rtc_frontend: timing, vblank fetch/commit, abort, alarm, reset.
module tb_vga_rtc_frontend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rtcin;
  logic        alarm_ack;
  logic        dato_aa;
  logic [7:0]  dato;
  logic [7:0]  dato_s;

  logic        hsync, vsync, video_on, pixel_tick, frame_valid, fetch_err, alarma;
  logic [9:0]  pixel_x, pixel_y;
  logic [3:0]  selector;
  logic [23:0] field_data;

  logic        hsync_s, vsync_s, video_on_s, pixel_tick_s, frame_valid_s, fetch_err_s, alarma_s;
  logic [9:0]  pixel_x_s, pixel_y_s;
  logic [3:0]  selector_s;
  logic [23:0] field_data_s;

  assign dato   = dato_aa ? 8'hAA : 8'h10 + {4'h0, selector};
  assign dato_s = 8'h20 + {4'h0, selector_s};

  vga_rtc_frontend #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b0),
    .NUM_FIELDS(3), .SEL_W(4), .SETTLE_CYC(2), .RING_FRAMES(3), .BLINK_FRAMES(30)
  ) dut (
    .clk(clk), .reset(reset), .dato(dato), .rtcin(rtcin), .alarm_ack(alarm_ack),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .selector_dato(selector),
    .field_data(field_data), .frame_valid(frame_valid), .fetch_err(fetch_err),
    .alarma(alarma)
  );

  // Settle time too long to fit three fields into the vertical blank.
  vga_rtc_frontend #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b0),
    .NUM_FIELDS(3), .SEL_W(4), .SETTLE_CYC(40), .RING_FRAMES(3), .BLINK_FRAMES(30)
  ) dut_slow (
    .clk(clk), .reset(reset), .dato(dato_s), .rtcin(rtcin), .alarm_ack(alarm_ack),
    .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s), .pixel_tick(pixel_tick_s),
    .pixel_x(pixel_x_s), .pixel_y(pixel_y_s), .selector_dato(selector_s),
    .field_data(field_data_s), .frame_valid(frame_valid_s), .fetch_err(fetch_err_s),
    .alarma(alarma_s)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          fast_err_cnt = 0;
  int          slow_fv_cnt = 0;
  logic [23:0] exp_q[$];

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (fetch_err === 1'b1) fast_err_cnt++;
      if (frame_valid_s === 1'b1) slow_fv_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sel(input logic [3:0] s, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (selector === s) ok = 1'b1;
    end
  endtask

  task automatic wait_fv(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (frame_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_slow_err(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (fetch_err_s === 1'b1) ok = 1'b1;
    end
  endtask

  // Returns at the negedge just after the posedge on which v wraps to 0.
  task automatic wait_vwrap(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (pixel_tick === 1'b1 && pixel_x === 10'd13 && pixel_y === 10'd7) ok = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        ok;
    int          cnt_a;
    int          cnt_b;
    logic [23:0] exp_fd;

    reset     = 1'b0;
    rtcin     = 1'b0;
    alarm_ack = 1'b0;
    dato_aa   = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_hsync", {31'd0, hsync}, 32'd1);
    check("rst_vsync", {31'd0, vsync}, 32'd1);
    check("rst_video_on", {31'd0, video_on}, 32'd0);
    check("rst_pixel_tick", {31'd0, pixel_tick}, 32'd0);
    check("rst_pixel_x", {22'd0, pixel_x}, 32'd0);
    check("rst_selector", {28'd0, selector}, 32'hF);
    check("rst_field_data", {8'd0, field_data}, 32'd0);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_alarma", {31'd0, alarma}, 32'd0);

    exp_q.push_back(24'h121110);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      check("pixel_tick_phase", {31'd0, pixel_tick}, (i % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    cnt_a = 0;
    repeat (28) begin
      if (hsync === 1'b0) cnt_a++;
      @(negedge clk);
    end
    check("hsync_low_clks_per_line", cnt_a, 32'd4);

    wait_fv(ok);
    check("first_commit_seen", {31'd0, ok}, 32'd1);
    exp_fd = exp_q.pop_front();
    check("first_commit_data", {8'd0, field_data}, {8'd0, exp_fd});
    @(negedge clk);
    check("frame_valid_one_clk", {31'd0, frame_valid}, 32'd0);

    wait_slow_err(ok);
    check("slow_abort_seen", {31'd0, ok}, 32'd1);
    check("slow_field_data_kept", {8'd0, field_data_s}, 32'd0);
    @(negedge clk);
    check("slow_fetch_err_one_clk", {31'd0, fetch_err_s}, 32'd0);

    cnt_a = 0;
    cnt_b = 0;
    repeat (224) begin
      if (vsync === 1'b0) cnt_a++;
      if (video_on === 1'b1) cnt_b++;
      @(negedge clk);
    end
    check("vsync_low_clks_per_frame", cnt_a, 32'd28);
    check("video_on_clks_per_frame", cnt_b, 32'd64);

    wait_sel(4'd1, ok);
    check("mid_fetch_reached", {31'd0, ok}, 32'd1);
    dato_aa = 1'b1;
    exp_q.push_back(24'hAAAA10);
    exp_q.push_back(24'hAAAAAA);
    wait_sel(4'd2, ok);
    check("no_partial_update", {8'd0, field_data}, 32'h121110);
    wait_fv(ok);
    check("mixed_commit_seen", {31'd0, ok}, 32'd1);
    exp_fd = exp_q.pop_front();
    check("mixed_commit_data", {8'd0, field_data}, {8'd0, exp_fd});
    wait_fv(ok);
    check("aa_commit_seen", {31'd0, ok}, 32'd1);
    exp_fd = exp_q.pop_front();
    check("aa_commit_data", {8'd0, field_data}, {8'd0, exp_fd});

    rtcin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("set_beats_ack", {31'd0, alarma}, 32'd1);
    wait_vwrap(ok);
    check("ring_after_wrap1", {30'd0, ok, alarma}, 32'd3);
    wait_vwrap(ok);
    check("ring_after_wrap2", {30'd0, ok, alarma}, 32'd3);
    wait_vwrap(ok);
    check("ring_timeout_wrap3", {30'd0, ok, alarma}, 32'd2);

    rtcin = 1'b0;
    repeat (4) @(negedge clk);
    rtcin = 1'b1;
    repeat (4) @(negedge clk);
    check("ring_set_again", {31'd0, alarma}, 32'd1);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("ack_clears_ring", {31'd0, alarma}, 32'd0);

    dato_aa = 1'b0;
    wait_sel(4'd1, ok);
    check("fetch_before_reset", {31'd0, ok}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midfetch_rst_selector", {28'd0, selector}, 32'hF);
    check("midfetch_rst_field_data", {8'd0, field_data}, 32'd0);
    check("midfetch_rst_pulses", {30'd0, frame_valid, fetch_err}, 32'd0);
    @(negedge clk);
    check("midfetch_rst_pulses_hold", {30'd0, frame_valid, fetch_err}, 32'd0);
    exp_q.push_back(24'h121110);
    reset = 1'b1;
    wait_fv(ok);
    check("post_reset_commit_seen", {31'd0, ok}, 32'd1);
    exp_fd = exp_q.pop_front();
    check("post_reset_commit_data", {8'd0, field_data}, {8'd0, exp_fd});

    check("fast_never_aborts", fast_err_cnt, 32'd0);
    check("slow_never_commits", slow_fv_cnt, 32'd0);
    check("slow_field_data_final", {8'd0, field_data_s}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
